// File: rtl/discovery_reply_send_if.sv
// Bundles the discovery handshake with sdr_receive and the UDP transmit port.
// The master side is the reply sender; the slave side is its environment.
interface discovery_reply_send_if;
    logic        discovery_reply;
    logic        discovery_ACK;
    logic        sending_sync;
    logic        run;
    logic [47:0] local_mac;
    logic        udp_tx_grant;
    logic        udp_tx_request;
    logic [15:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_valid;
    logic        udp_tx_last;

    modport master (
        input  discovery_reply,
        input  run,
        input  local_mac,
        input  udp_tx_grant,
        output discovery_ACK,
        output sending_sync,
        output udp_tx_request,
        output udp_tx_length,
        output udp_tx_data,
        output udp_tx_valid,
        output udp_tx_last
    );

    modport slave (
        output discovery_reply,
        output run,
        output local_mac,
        output udp_tx_grant,
        input  discovery_ACK,
        input  sending_sync,
        input  udp_tx_request,
        input  udp_tx_length,
        input  udp_tx_data,
        input  udp_tx_valid,
        input  udp_tx_last
    );
endinterface

// File: rtl/discovery_reply_send.sv
// HPSDR discovery reply sender. Accepts one request per assertion of
// discovery_reply, asks for the UDP transmit path and streams the reply
// payload one byte per tx_clock cycle.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | nothing pending; waiting for an armed discovery_reply
// REQUEST | udp_tx_request high, waiting for grant or timeout
// SEND    | streaming payload bytes, one per cycle, no back-pressure
module discovery_reply_send #(
    parameter logic [7:0] CODE_VERSION  = 8'd30,
    parameter logic [7:0] BOARD_ID      = 8'd1,
    parameter int         PAYLOAD_LEN   = 60,
    parameter int         GRANT_TIMEOUT = 1_250_000
) (
    input logic tx_clock,
    input logic reset,
    discovery_reply_send_if.master bus
);

    localparam int         TW       = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    byte_cnt, byte_cnt_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic          armed;
    logic          ack;
    logic          run_q;
    logic [47:0]   mac_q;
    logic          accept;
    logic [7:0]    payload_byte;

    // Edge qualification: armed is consumed by an accept and only restored
    // once the requester has dropped discovery_reply.
    assign accept = (state == IDLE) && bus.discovery_reply && armed;

    // State, byte counter and grant timeout counter.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
        end
    end

    // Next-state logic; a grant beats a simultaneous timeout expiry.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = REQUEST;
                    tmo_cnt_nxt = TW'(GRANT_TIMEOUT);
                end
            end
            REQUEST: begin
                if (bus.udp_tx_grant) begin
                    state_nxt    = SEND;
                    byte_cnt_nxt = '0;
                end else if (tmo_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - TW'(1);
                end
            end
            SEND: begin
                if (byte_cnt == LAST_IDX) begin
                    state_nxt    = IDLE;
                    byte_cnt_nxt = '0;
                end else begin
                    byte_cnt_nxt = byte_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                byte_cnt_nxt = '0;
                tmo_cnt_nxt  = '0;
            end
        endcase
    end

    // Handshake with sdr_receive and snapshot of run/MAC at acceptance.
    // ACK follows discovery_reply, not the FSM, so it can outlast the packet.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            armed <= 1'b1;
            ack   <= 1'b0;
            run_q <= 1'b0;
            mac_q <= '0;
        end else if (accept) begin
            armed <= 1'b0;
            ack   <= 1'b1;
            run_q <= bus.run;
            mac_q <= bus.local_mac;
        end else if (!bus.discovery_reply) begin
            armed <= 1'b1;
            ack   <= 1'b0;
        end
    end

    // Reply payload, built only from the latched copies of run and MAC.
    always_comb begin
        payload_byte = 8'h00;
        case (byte_cnt)
            8'd0:    payload_byte = 8'hEF;
            8'd1:    payload_byte = 8'hFE;
            8'd2:    payload_byte = run_q ? 8'h03 : 8'h02;
            8'd3:    payload_byte = mac_q[47:40];
            8'd4:    payload_byte = mac_q[39:32];
            8'd5:    payload_byte = mac_q[31:24];
            8'd6:    payload_byte = mac_q[23:16];
            8'd7:    payload_byte = mac_q[15:8];
            8'd8:    payload_byte = mac_q[7:0];
            8'd9:    payload_byte = CODE_VERSION;
            8'd10:   payload_byte = BOARD_ID;
            default: payload_byte = 8'h00;
        endcase
    end

    // Outputs decode directly from registered state, so a reset clears
    // them on the following cycle with no trailing bytes.
    always_comb begin
        bus.udp_tx_request = 1'b0;
        bus.udp_tx_valid   = 1'b0;
        bus.udp_tx_last    = 1'b0;
        bus.udp_tx_data    = 8'h00;
        bus.sending_sync   = 1'b0;
        case (state)
            REQUEST: begin
                bus.udp_tx_request = 1'b1;
                bus.sending_sync   = 1'b1;
            end
            SEND: begin
                bus.udp_tx_valid = 1'b1;
                bus.udp_tx_data  = payload_byte;
                bus.udp_tx_last  = (byte_cnt == LAST_IDX);
                bus.sending_sync = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.udp_tx_length = 16'(PAYLOAD_LEN);
    assign bus.discovery_ACK = ack;

endmodule

// File: tb/tb_discovery_reply_send.sv
// Directed bench for discovery_reply_send: basic reply, run latching,
// held request, grant timeout, reset mid-send and the ACK handshake.
module tb_discovery_reply_send;

    localparam int PLEN = 60;
    localparam int GTO  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    discovery_reply_send_if bus();

    discovery_reply_send #(
        .CODE_VERSION (8'd30),
        .BOARD_ID     (8'd1),
        .PAYLOAD_LEN  (PLEN),
        .GRANT_TIMEOUT(GTO)
    ) dut (
        .tx_clock(clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] pkt[$];
    int         n_pkts   = 0;
    int         last_pos = -1;
    int         n_valid  = 0;

    always @(negedge clk) begin
        if (bus.udp_tx_valid) begin
            pkt.push_back(bus.udp_tx_data);
            n_valid++;
            if (bus.udp_tx_last) begin
                last_pos = pkt.size();
                n_pkts++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input bit r, input logic [47:0] m);
        case (i)
            0:  return 8'hEF;
            1:  return 8'hFE;
            2:  return r ? 8'h03 : 8'h02;
            3:  return m[47:40];
            4:  return m[39:32];
            5:  return m[31:24];
            6:  return m[23:16];
            7:  return m[15:8];
            8:  return m[7:0];
            9:  return 8'h1E;
            10: return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.sending_sync && k < 300) begin
            step(1);
            k++;
        end
        chk({tag, "_idle_to"}, 64'(bus.sending_sync), 64'd0);
    endtask

    task automatic check_pkt(input string tag, input bit r, input logic [47:0] m);
        chk({tag, "_len"}, 64'(pkt.size()), 64'(PLEN));
        chk({tag, "_lastpos"}, 64'(last_pos), 64'(PLEN));
        for (int i = 0; i < pkt.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 64'(pkt[i]), 64'(exp_byte(i, r, m)));
        pkt.delete();
        last_pos = -1;
    endtask

    task automatic grant_pulse();
        bus.udp_tx_grant = 1'b1;
        step(1);
        bus.udp_tx_grant = 1'b0;
    endtask

    localparam logic [47:0] MAC_A = 48'h001CC0A213DD;
    localparam logic [47:0] MAC_B = 48'h0A0B0C0D0E0F;

    initial begin
        int pk0;
        int nv0;
        bus.discovery_reply = 1'b0;
        bus.run             = 1'b0;
        bus.local_mac       = MAC_A;
        bus.udp_tx_grant    = 1'b0;
        rst = 1'b1;
        step(3);
        chk("rst_req",   64'(bus.udp_tx_request), 64'd0);
        chk("rst_valid", 64'(bus.udp_tx_valid),   64'd0);
        chk("rst_ack",   64'(bus.discovery_ACK),  64'd0);
        chk("rst_sync",  64'(bus.sending_sync),   64'd0);
        chk("rst_data",  64'(bus.udp_tx_data),    64'd0);
        chk("rst_len",   64'(bus.udp_tx_length),  64'd60);
        rst = 1'b0;
        step(2);

        // 1: basic reply, grant three cycles after request
        bus.discovery_reply = 1'b1;
        step(1);
        chk("t1_req",  64'(bus.udp_tx_request), 64'd1);
        chk("t1_sync", 64'(bus.sending_sync),   64'd1);
        chk("t1_ack",  64'(bus.discovery_ACK),  64'd1);
        chk("t1_len",  64'(bus.udp_tx_length),  64'd60);
        bus.discovery_reply = 1'b0;
        step(3);
        chk("t1_nvalid", 64'(bus.udp_tx_valid), 64'd0);
        grant_pulse();
        chk("t1_v0",   64'(bus.udp_tx_valid),   64'd1);
        chk("t1_d0",   64'(bus.udp_tx_data),    64'hEF);
        chk("t1_req0", 64'(bus.udp_tx_request), 64'd0);
        step(PLEN - 1);
        chk("t1_last", 64'(bus.udp_tx_last),  64'd1);
        chk("t1_vl",   64'(bus.udp_tx_valid), 64'd1);
        step(1);
        chk("t1_sync_end",  64'(bus.sending_sync), 64'd0);
        chk("t1_valid_end", 64'(bus.udp_tx_valid), 64'd0);
        chk("t1_last_end",  64'(bus.udp_tx_last),  64'd0);
        check_pkt("t1", 1'b0, MAC_A);

        // 2: run latched at acceptance, toggling during SEND has no effect
        bus.run = 1'b1;
        bus.discovery_reply = 1'b1;
        step(1);
        bus.run = 1'b0;
        bus.discovery_reply = 1'b0;
        grant_pulse();
        step(1);
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
        wait_idle("t2");
        check_pkt("t2", 1'b1, MAC_A);

        // 3: held request yields exactly one packet until re-armed
        pk0 = n_pkts;
        bus.discovery_reply = 1'b1;
        step(2);
        grant_pulse();
        wait_idle("t3a");
        step(200);
        chk("t3_one_pkt", 64'(n_pkts - pk0), 64'd1);
        chk("t3_no_req",  64'(bus.udp_tx_request), 64'd0);
        chk("t3_ack_held", 64'(bus.discovery_ACK), 64'd1);
        check_pkt("t3a", 1'b0, MAC_A);
        bus.discovery_reply = 1'b0;
        step(1);
        bus.discovery_reply = 1'b1;
        step(1);
        chk("t3_rereq", 64'(bus.udp_tx_request), 64'd1);
        grant_pulse();
        wait_idle("t3b");
        chk("t3_two_pkt", 64'(n_pkts - pk0), 64'd2);
        check_pkt("t3b", 1'b0, MAC_A);
        bus.discovery_reply = 1'b0;
        step(2);

        // 4a: no grant, abandon 21 cycles after entering REQUEST
        nv0 = n_valid;
        bus.discovery_reply = 1'b1;
        step(1);
        bus.discovery_reply = 1'b0;
        step(GTO);
        chk("t4_req_hold", 64'(bus.udp_tx_request), 64'd1);
        step(1);
        chk("t4_req_drop",  64'(bus.udp_tx_request), 64'd0);
        chk("t4_sync_drop", 64'(bus.sending_sync),   64'd0);
        step(5);
        chk("t4_novalid", 64'(n_valid - nv0), 64'd0);
        // 4b: grant on the expiry cycle still wins
        bus.discovery_reply = 1'b1;
        step(1);
        bus.discovery_reply = 1'b0;
        step(GTO);
        chk("t4b_req", 64'(bus.udp_tx_request), 64'd1);
        grant_pulse();
        chk("t4b_valid", 64'(bus.udp_tx_valid), 64'd1);
        wait_idle("t4b");
        check_pkt("t4b", 1'b0, MAC_A);

        // 5: reset at payload byte 30, then a fresh full packet
        bus.local_mac = MAC_B;
        bus.discovery_reply = 1'b1;
        step(1);
        bus.discovery_reply = 1'b0;
        grant_pulse();
        step(30);
        chk("t5_b30_valid", 64'(bus.udp_tx_valid), 64'd1);
        rst = 1'b1;
        step(1);
        chk("t5_valid", 64'(bus.udp_tx_valid),   64'd0);
        chk("t5_last",  64'(bus.udp_tx_last),    64'd0);
        chk("t5_req",   64'(bus.udp_tx_request), 64'd0);
        chk("t5_sync",  64'(bus.sending_sync),   64'd0);
        chk("t5_ack",   64'(bus.discovery_ACK),  64'd0);
        chk("t5_data",  64'(bus.udp_tx_data),    64'd0);
        chk("t5_len",   64'(bus.udp_tx_length),  64'd60);
        rst = 1'b0;
        step(2);
        chk("t5_partial", 64'(pkt.size()), 64'd31);
        pkt.delete();
        last_pos = -1;
        bus.discovery_reply = 1'b1;
        step(1);
        bus.discovery_reply = 1'b0;
        grant_pulse();
        wait_idle("t5");
        check_pkt("t5", 1'b0, MAC_B);

        // 6: sdr_receive drops reply one cycle after seeing ACK
        bus.local_mac = MAC_A;
        bus.discovery_reply = 1'b1;
        step(1);
        chk("t6_ack_rise", 64'(bus.discovery_ACK), 64'd1);
        bus.local_mac = MAC_B;
        step(1);
        bus.discovery_reply = 1'b0;
        chk("t6_ack_still", 64'(bus.discovery_ACK), 64'd1);
        step(1);
        chk("t6_ack_fall", 64'(bus.discovery_ACK), 64'd0);
        chk("t6_req",      64'(bus.udp_tx_request), 64'd1);
        grant_pulse();
        wait_idle("t6");
        check_pkt("t6", 1'b0, MAC_A);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
